// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read slave port between two masters, one transaction in flight.
// Optional R-channel idle timeout with SLVERR completion is enabled by defining ARB_TIMEOUT_EN.
module axi_read_arbiter #(
  parameter int BusWidth      = 32,
  parameter int TagBits       = 4,
  parameter int TimeoutCycles = 255
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [2*TagBits-1:0]   M_ARID,
  input  logic [2*BusWidth-1:0]  M_ARADDR,
  input  logic [15:0]            M_ARCTRL,
  input  logic [1:0]             M_ARVALID,
  output logic [1:0]             M_ARREADY,
  output logic [BusWidth-1:0]    M_RDATA,
  output logic [1:0]             M_RRESP,
  output logic                   M_RLAST,
  output logic [1:0]             M_RVALID,
  input  logic [1:0]             M_RREADY,
  output logic [TagBits-1:0]     S_ARID,
  output logic [BusWidth-1:0]    S_ARADDR,
  output logic [3:0]             S_ARLEN,
  output logic [1:0]             S_ARSIZE,
  output logic [1:0]             S_ARBURST,
  output logic                   S_ARVALID,
  input  logic                   S_ARREADY,
  input  logic [TagBits-1:0]     S_RID,
  input  logic [BusWidth-1:0]    S_RDATA,
  input  logic [1:0]             S_RRESP,
  input  logic                   S_RLAST,
  input  logic                   S_RVALID,
  output logic                   S_RREADY,
  output logic [1:0]             GRANT
);

`ifdef ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;
  localparam int CntW = (TimeoutCycles > 255) ? $clog2(TimeoutCycles + 1) : 8;
  logic [CntW-1:0] idle_cnt;
`else
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
`endif

  if (TimeoutCycles < 1) begin : g_bad_timeout
    $error("TimeoutCycles must be at least 1");
  end

  state_t state;
  logic   ptr;
  logic   win;
  logic   gidx;
  logic   rid_match;
  logic   fwd_last;

  // Priority pointer only breaks ties; a sole requester always wins.
  assign win       = (M_ARVALID == 2'b11) ? ptr : M_ARVALID[1];
  assign gidx      = GRANT[1];
  assign rid_match = (S_RID == S_ARID);
  assign fwd_last  = S_RVALID && rid_match && M_RREADY[gidx] && S_RLAST;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      GRANT     <= '0;
      S_ARID    <= '0;
      S_ARADDR  <= '0;
      S_ARLEN   <= '0;
      S_ARSIZE  <= '0;
      S_ARBURST <= '0;
      S_ARVALID <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      idle_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|M_ARVALID) begin
            S_ARID    <= win ? M_ARID[2*TagBits-1:TagBits]    : M_ARID[TagBits-1:0];
            S_ARADDR  <= win ? M_ARADDR[2*BusWidth-1:BusWidth] : M_ARADDR[BusWidth-1:0];
            S_ARLEN   <= win ? M_ARCTRL[15:12] : M_ARCTRL[7:4];
            S_ARSIZE  <= win ? M_ARCTRL[11:10] : M_ARCTRL[3:2];
            S_ARBURST <= win ? M_ARCTRL[9:8]   : M_ARCTRL[1:0];
            GRANT     <= win ? 2'b10 : 2'b01;
            S_ARVALID <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (S_ARREADY) begin
            S_ARVALID <= 1'b0;
            state     <= DATA;
`ifdef ARB_TIMEOUT_EN
            idle_cnt  <= '0;
`endif
          end
        end
        DATA: begin
          if (fwd_last) begin
            GRANT <= '0;
            ptr   <= ~gidx;
            state <= IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (S_RVALID) begin
            idle_cnt <= '0;
          end else if (idle_cnt == CntW'(TimeoutCycles - 1)) begin
            state <= ERR;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
`endif
        end
`ifdef ARB_TIMEOUT_EN
        ERR: begin
          if (M_RREADY[gidx]) begin
            GRANT <= '0;
            ptr   <= ~gidx;
            state <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Reset gates the combinational accept so every master-side output reads 0 while ARESET is high.
  always_comb begin
    M_ARREADY = '0;
    M_RVALID  = '0;
    M_RDATA   = '0;
    M_RRESP   = '0;
    M_RLAST   = 1'b0;
    S_RREADY  = 1'b0;
    case (state)
      IDLE: begin
        if (!ARESET && (|M_ARVALID)) M_ARREADY[win] = 1'b1;
      end
      DATA: begin
        M_RDATA        = S_RDATA;
        M_RRESP        = S_RRESP;
        M_RLAST        = S_RLAST;
        M_RVALID[gidx] = S_RVALID & rid_match;
        S_RREADY       = (S_RVALID & ~rid_match) | M_RREADY[gidx];
      end
`ifdef ARB_TIMEOUT_EN
      ERR: begin
        M_RVALID[gidx] = 1'b1;
        M_RLAST        = 1'b1;
        M_RRESP        = 2'b10;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed self-checking bench for axi_read_arbiter: reset, single burst, round-robin,
// AR stall, R backpressure, RID mismatch drain, async reset mid-transaction (and timeout if enabled).
module tb_axi_read_arbiter;
  localparam int BW = 32;
  localparam int TB = 4;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic [2*TB-1:0] M_ARID;
  logic [2*BW-1:0] M_ARADDR;
  logic [15:0]     M_ARCTRL;
  logic [1:0]      M_ARVALID;
  logic [1:0]      M_ARREADY;
  logic [BW-1:0]   M_RDATA;
  logic [1:0]      M_RRESP;
  logic            M_RLAST;
  logic [1:0]      M_RVALID;
  logic [1:0]      M_RREADY;
  logic [TB-1:0]   S_ARID;
  logic [BW-1:0]   S_ARADDR;
  logic [3:0]      S_ARLEN;
  logic [1:0]      S_ARSIZE;
  logic [1:0]      S_ARBURST;
  logic            S_ARVALID;
  logic            S_ARREADY;
  logic [TB-1:0]   S_RID;
  logic [BW-1:0]   S_RDATA;
  logic [1:0]      S_RRESP;
  logic            S_RLAST;
  logic            S_RVALID;
  logic            S_RREADY;
  logic [1:0]      GRANT;

  int errors = 0;
  int checks = 0;

  always #5 ACLK = ~ACLK;

  axi_read_arbiter #(.BusWidth(BW), .TagBits(TB), .TimeoutCycles(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARCTRL(M_ARCTRL), .M_ARVALID(M_ARVALID),
    .M_ARREADY(M_ARREADY), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
    .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE),
    .S_ARBURST(S_ARBURST), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY), .GRANT(GRANT)
  );

  // Master0: ID 3, addr 0x100, LEN 3/SIZE 2/BURST 1. Master1: ID 9, addr 0x300, LEN 1.
  initial begin
    M_ARID    = {4'h9, 4'h3};
    M_ARADDR  = {32'h0000_0300, 32'h0000_0100};
    M_ARCTRL  = {8'h19, 8'h39};
  end

  task automatic step;
    @(posedge ACLK);
    #2;
  endtask

  // Drive-only helper: from ADDR, accept the AR and return one matching RLAST beat.
  task automatic finish_txn(input logic [TB-1:0] id);
    S_ARREADY = 1'b1;
    step();
    S_ARREADY = 1'b0;
    S_RVALID  = 1'b1;
    S_RID     = id;
    S_RLAST   = 1'b1;
    M_RREADY  = 2'b11;
    step();
    S_RVALID  = 1'b0;
    S_RLAST   = 1'b0;
    M_RREADY  = 2'b00;
  endtask

  task automatic test_reset;
    ARESET = 1'b1;
    M_ARVALID = 2'b01;
    step();
    checks++; if (GRANT !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", GRANT); end
    checks++; if (S_ARVALID !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", S_ARVALID); end
    checks++; if (M_ARREADY !== 2'b00) begin errors++; $display("FAIL reset_arready: got %b want 00", M_ARREADY); end
    checks++; if (S_RREADY !== 1'b0 || M_RVALID !== 2'b00) begin errors++; $display("FAIL reset_r: rready=%b rvalid=%b want 0/00", S_RREADY, M_RVALID); end
    M_ARVALID = 2'b00;
    ARESET = 1'b0;
    step();
  endtask

  task automatic test_single;
    M_ARVALID = 2'b01;
    #1;
    checks++; if (M_ARREADY !== 2'b01) begin errors++; $display("FAIL single_arready: got %b want 01", M_ARREADY); end
    step();
    M_ARVALID = 2'b00;
    checks++; if (S_ARVALID !== 1'b1 || S_ARADDR !== 32'h100 || S_ARLEN !== 4'd3 || S_ARID !== 4'h3)
      begin errors++; $display("FAIL single_ar: valid=%b addr=%h len=%0d id=%h want 1/100/3/3", S_ARVALID, S_ARADDR, S_ARLEN, S_ARID); end
    checks++; if (S_ARSIZE !== 2'b10 || S_ARBURST !== 2'b01 || GRANT !== 2'b01)
      begin errors++; $display("FAIL single_ctrl: size=%b burst=%b grant=%b want 10/01/01", S_ARSIZE, S_ARBURST, GRANT); end
    S_ARREADY = 1'b1;
    step();
    S_ARREADY = 1'b0;
    checks++; if (S_ARVALID !== 1'b0) begin errors++; $display("FAIL single_arvalid_drop: got %b want 0", S_ARVALID); end
    M_RREADY = 2'b11;
    for (int i = 0; i < 4; i++) begin
      S_RVALID = 1'b1;
      S_RID    = 4'h3;
      S_RDATA  = 32'hA0 + i;
      S_RLAST  = (i == 3);
      #1;
      checks++; if (M_RVALID !== 2'b01 || M_RDATA !== 32'hA0 + i || S_RREADY !== 1'b1 || M_RLAST !== (i == 3))
        begin errors++; $display("FAIL single_beat%0d: rvalid=%b data=%h rready=%b last=%b", i, M_RVALID, M_RDATA, S_RREADY, M_RLAST); end
      step();
    end
    S_RVALID = 1'b0;
    S_RLAST  = 1'b0;
    M_RREADY = 2'b00;
    #1;
    checks++; if (GRANT !== 2'b00 || M_RVALID !== 2'b00) begin errors++; $display("FAIL single_done: grant=%b rvalid=%b want 00/00", GRANT, M_RVALID); end
  endtask

  task automatic test_round_robin;
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    step();
    M_ARVALID = 2'b11;
    #1;
    checks++; if (M_ARREADY !== 2'b01) begin errors++; $display("FAIL rr_first_arready: got %b want 01", M_ARREADY); end
    step();
    checks++; if (GRANT !== 2'b01 || S_ARADDR !== 32'h100) begin errors++; $display("FAIL rr_first_grant: grant=%b addr=%h want 01/100", GRANT, S_ARADDR); end
    finish_txn(4'h3);
    #1;
    checks++; if (GRANT !== 2'b00 || M_ARREADY !== 2'b10) begin errors++; $display("FAIL rr_second_arready: grant=%b arready=%b want 00/10", GRANT, M_ARREADY); end
    step();
    checks++; if (GRANT !== 2'b10 || S_ARADDR !== 32'h300 || S_ARID !== 4'h9 || S_ARLEN !== 4'd1)
      begin errors++; $display("FAIL rr_second_grant: grant=%b addr=%h id=%h len=%0d want 10/300/9/1", GRANT, S_ARADDR, S_ARID, S_ARLEN); end
    S_ARREADY = 1'b1;
    step();
    S_ARREADY = 1'b0;
    S_RVALID = 1'b1; S_RID = 4'h9; S_RLAST = 1'b1; M_RREADY = 2'b11;
    #1;
    checks++; if (M_RVALID !== 2'b10) begin errors++; $display("FAIL rr_second_beat: rvalid=%b want 10", M_RVALID); end
    step();
    S_RVALID = 1'b0; S_RLAST = 1'b0; M_RREADY = 2'b00;
    #1;
    checks++; if (M_ARREADY !== 2'b01) begin errors++; $display("FAIL rr_third_arready: got %b want 01", M_ARREADY); end
    step();
    M_ARVALID = 2'b00;
    checks++; if (GRANT !== 2'b01) begin errors++; $display("FAIL rr_third_grant: got %b want 01", GRANT); end
    finish_txn(4'h3);
  endtask

  task automatic test_stall;
    M_ARADDR[31:0] = 32'h200;
    M_ARVALID = 2'b01;
    step();
    M_ARVALID = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (S_ARVALID !== 1'b1 || S_ARADDR !== 32'h200 || M_ARREADY !== 2'b00)
        begin errors++; $display("FAIL stall_cyc%0d: arvalid=%b addr=%h arready=%b want 1/200/00", i, S_ARVALID, S_ARADDR, M_ARREADY); end
      step();
    end
    M_ARVALID = 2'b00;
    M_ARADDR[31:0] = 32'h100;
    finish_txn(4'h3);
  endtask

  task automatic test_backpressure;
    M_ARVALID = 2'b10;
    step();
    M_ARVALID = 2'b00;
    S_ARREADY = 1'b1;
    step();
    S_ARREADY = 1'b0;
    S_RVALID = 1'b1; S_RID = 4'h9; S_RLAST = 1'b1; S_RDATA = 32'hDEAD; M_RREADY = 2'b01;
    #1;
    checks++; if (S_RREADY !== 1'b0 || M_RVALID !== 2'b10) begin errors++; $display("FAIL bp_hold: rready=%b rvalid=%b want 0/10", S_RREADY, M_RVALID); end
    step();
    checks++; if (GRANT !== 2'b10 || M_RVALID !== 2'b10 || M_RDATA !== 32'hDEAD)
      begin errors++; $display("FAIL bp_held: grant=%b rvalid=%b data=%h want 10/10/dead", GRANT, M_RVALID, M_RDATA); end
    M_RREADY = 2'b10;
    #1;
    checks++; if (S_RREADY !== 1'b1) begin errors++; $display("FAIL bp_release: rready=%b want 1", S_RREADY); end
    step();
    S_RVALID = 1'b0; S_RLAST = 1'b0; M_RREADY = 2'b00;
    checks++; if (GRANT !== 2'b00) begin errors++; $display("FAIL bp_done: grant=%b want 00", GRANT); end
  endtask

  task automatic test_rid_mismatch;
    M_ARVALID = 2'b01;
    step();
    M_ARVALID = 2'b00;
    S_ARREADY = 1'b1;
    step();
    S_ARREADY = 1'b0;
    S_RVALID = 1'b1; S_RID = 4'h5; S_RLAST = 1'b1; M_RREADY = 2'b00;
    #1;
    checks++; if (S_RREADY !== 1'b1 || M_RVALID !== 2'b00) begin errors++; $display("FAIL rid_drain: rready=%b rvalid=%b want 1/00", S_RREADY, M_RVALID); end
    step();
    checks++; if (GRANT !== 2'b01) begin errors++; $display("FAIL rid_still_granted: grant=%b want 01", GRANT); end
    S_RID = 4'h3; M_RREADY = 2'b01;
    #1;
    checks++; if (M_RVALID !== 2'b01 || S_RREADY !== 1'b1) begin errors++; $display("FAIL rid_forward: rvalid=%b rready=%b want 01/1", M_RVALID, S_RREADY); end
    step();
    S_RVALID = 1'b0; S_RLAST = 1'b0; M_RREADY = 2'b00;
    M_ARVALID = 2'b10;
    #1;
    checks++; if (GRANT !== 2'b00 || M_ARREADY !== 2'b10) begin errors++; $display("FAIL rid_idle: grant=%b arready=%b want 00/10", GRANT, M_ARREADY); end
    M_ARVALID = 2'b00;
    #1;
  endtask

  task automatic test_reset_mid;
    M_ARVALID = 2'b01;
    step();
    M_ARVALID = 2'b00;
    S_ARREADY = 1'b1;
    step();
    S_ARREADY = 1'b0;
    S_RVALID = 1'b1; S_RID = 4'h3; S_RDATA = 32'h55; M_RREADY = 2'b01;
    #1;
    ARESET = 1'b1;
    #1;
    checks++; if (GRANT !== 2'b00 || M_RVALID !== 2'b00 || S_RREADY !== 1'b0 || S_ARVALID !== 1'b0 || M_RDATA !== 32'h0)
      begin errors++; $display("FAIL reset_mid: grant=%b rvalid=%b rready=%b arvalid=%b data=%h want all 0", GRANT, M_RVALID, S_RREADY, S_ARVALID, M_RDATA); end
    S_RVALID = 1'b0; M_RREADY = 2'b00;
    step();
    ARESET = 1'b0;
    step();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout;
    M_ARVALID = 2'b10;
    step();
    M_ARVALID = 2'b00;
    S_ARREADY = 1'b1;
    step();
    S_ARREADY = 1'b0;
    step(); step(); step();
    checks++; if (M_RVALID !== 2'b00) begin errors++; $display("FAIL to_early: rvalid=%b want 00", M_RVALID); end
    step();
    checks++; if (M_RVALID !== 2'b10 || M_RRESP !== 2'b10 || M_RLAST !== 1'b1 || M_RDATA !== 32'h0 || S_RREADY !== 1'b0)
      begin errors++; $display("FAIL to_err: rvalid=%b resp=%b last=%b data=%h rready=%b", M_RVALID, M_RRESP, M_RLAST, M_RDATA, S_RREADY); end
    M_RREADY = 2'b10;
    step();
    M_RREADY = 2'b00;
    checks++; if (GRANT !== 2'b00) begin errors++; $display("FAIL to_done: grant=%b want 00", GRANT); end
  endtask
`endif

  initial begin
    M_ARVALID = '0; M_RREADY = '0; S_ARREADY = 1'b0;
    S_RID = '0; S_RDATA = '0; S_RRESP = '0; S_RLAST = 1'b0; S_RVALID = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_backpressure();
    test_rid_mismatch();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares one AXI read slave port between two read masters. Arbitration is round-robin.
- Allows one transaction in flight: the winning master's AR request is forwarded, and its R beats are routed back to it until the RLAST handshake completes.
- Sits between the read masters and the memory slave, on the same ACLK domain.

Parameters:
BusWidth, 32, address/data width
TagBits, 4, ID width
TimeoutCycles, 255, R-channel idle limit (used only with ARB_TIMEOUT_EN)

Ports:
ACLK  input  1  global clock, rising edge
ARESET  input  1  asynchronous reset, active-high
M_ARID  input  2*TagBits  per-master ARID, master0 in low slice
M_ARADDR  input  2*BusWidth  per-master ARADDR
M_ARCTRL  input  16  per-master {ARLEN[3:0],ARSIZE[1:0],ARBURST[1:0]}, 8 bits each
M_ARVALID  input  2  per-master request valid
M_ARREADY  output  2  per-master accept, one-hot or zero
M_RDATA  output  BusWidth  broadcast read data
M_RRESP  output  2  broadcast read response
M_RLAST  output  1  broadcast last beat
M_RVALID  output  2  per-master beat valid, one-hot or zero
M_RREADY  input  2  per-master beat ready
S_ARID  output  TagBits  to slave
S_ARADDR  output  BusWidth  to slave
S_ARLEN  output  4  to slave
S_ARSIZE  output  2  to slave
S_ARBURST  output  2  to slave
S_ARVALID  output  1  to slave
S_ARREADY  input  1  from slave
S_RID  input  TagBits  from slave
S_RDATA  input  BusWidth  from slave
S_RRESP  input  2  from slave
S_RLAST  input  1  from slave
S_RVALID  input  1  from slave
S_RREADY  output  1  to slave
GRANT  output  2  one-hot current owner, 0 when idle

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, priority pointer=master0.
  - All S_AR* registers, S_ARVALID, GRANT=0.
  - All M_* outputs 0 and S_RREADY=0.
  - Reset mid-transaction aborts silently: no R beat is generated.
- IDLE:
  - M_ARREADY is combinational: one-hot on the winner whenever any M_ARVALID is high.
  - Winner when both request: the priority pointer; otherwise the sole requester.
  - At that edge: latch the winner's ID/ADDR/CTRL into S_AR*, set GRANT=winner, S_ARVALID<=1, go to ADDR.
  - Request-to-S_ARVALID latency is 1 cycle.
  - S_RREADY=0 in IDLE.
- ADDR:
  - S_ARVALID and S_AR* held stable.
  - On the edge with S_ARREADY=1: S_ARVALID<=0, go to DATA.
  - M_ARREADY=0 in ADDR and DATA; new requests wait.
- DATA, pass-through combinational:
  - M_RDATA/M_RRESP/M_RLAST = S_R*.
  - M_RVALID[grant] = S_RVALID & (S_RID==latched ARID).
  - S_RREADY = M_RREADY[grant].
  - A beat with a mismatched RID is drained: S_RREADY=1, not forwarded, M_RVALID stays 0.
  - A forwarded handshake with S_RLAST=1 sets GRANT<=0, pointer <= the master that did not hold the grant, and returns to IDLE.
  - Back-to-back grants therefore have one IDLE cycle between them.
- Fairness: master0 and master1 both requesting continuously → grants alternate 0,1,0,1.
- A master deasserting M_ARVALID before acceptance is not latched, because the sample happens only in IDLE.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - An 8+-bit counter counts DATA cycles with S_RVALID=0. It clears on any S_RVALID and on entry to DATA.
  - When the count reaches TimeoutCycles, go to ERR.
  - ERR drives M_RVALID[grant]=1, M_RLAST=1, M_RRESP=2'b10 (SLVERR), M_RDATA=0, S_RREADY=0.
  - ERR holds these until M_RREADY[grant]=1, then returns to IDLE with the pointer rotated.
  - Late slave beats arriving after ERR are not drained.
- Undefined: no counter, no ERR state; DATA waits indefinitely.

Test Plan:
- Single request: M_ARVALID=01, ADDR0=0x100, LEN=3 → M_ARREADY=01 same cycle; S_ARVALID next cycle with S_ARADDR=0x100, S_ARLEN=3; 4 beats with RID match reach only M_RVALID[0]; GRANT=0 after the RLAST handshake.
- Simultaneous requests after reset: M_ARVALID=11 → master0 granted first; master1 granted on the IDLE cycle after master0's RLAST; then master0 again if still requesting.
- Stalled slave: S_ARREADY low for 5 cycles → S_ARVALID and S_ARADDR stable for all 5 cycles; M_ARREADY stays 00.
- Backpressure: M_RREADY[grant] low while S_RVALID=1 → S_RREADY=0 and the beat is held; completes when ready rises.
- RID mismatch beat followed by a matching RLAST beat → first beat drained with S_RREADY=1 and M_RVALID=00; second beat forwarded; state returns to IDLE.
- Reset asserted mid-DATA → all outputs 0 immediately. With ARB_TIMEOUT_EN and TimeoutCycles=4, no S_RVALID for 4 DATA cycles → M_RRESP=2'b10 and M_RLAST=1 to the granted master.
